// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the serial parity checker:
//   - state_t      : FSM state encoding (IDLE / DATA / PARITY)
//   - ERR_CNT_W    : width of the errored-frame counter
//   - ERR_CNT_MAX  : saturation value of the errored-frame counter
// -----------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    localparam int                   ERR_CNT_W   = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/serial_shift_reg.sv
// -----------------------------------------------------------------------------
// serial_shift_reg
// Right-shifting serial-to-parallel register. Each shift inserts bit_in at the
// MSB and moves everything one place toward bit 0, so a word sent LSB first
// ends up correctly aligned after DATA_BITS shifts.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears the register)
//   clear     synchronous clear, has priority over shift_en
//   shift_en  shift bit_in in this cycle
//   bit_in    serial input bit
//   data_q    parallel register contents
// -----------------------------------------------------------------------------
module serial_shift_reg #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data_q
);

    logic [DATA_BITS-1:0] sr_reg;
    logic [DATA_BITS-1:0] sr_next;

    // Per-bit next value; the top bit takes the new serial bit. Written bit by
    // bit so that DATA_BITS=1 needs no out-of-range slice.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_next
        if (gi == DATA_BITS - 1) begin : g_top
            assign sr_next[gi] = bit_in;
        end else begin : g_mid
            assign sr_next[gi] = sr_reg[gi+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else if (clear) begin
            sr_reg <= '0;
        end else if (shift_en) begin
            sr_reg <= sr_next;
        end
    end

    assign data_q = sr_reg;

endmodule

// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
// Receives framed serial data (DATA_BITS data bits LSB first, then one parity
// bit), checks the parity and reports the captured word plus an error flag at
// frame end. Counts errored frames with a saturating counter.
//
// Parameters:
//   DATA_BITS   data bits per frame (1..32)
//   ODD_PARITY  0 = even parity expected, 1 = odd parity expected
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       frame-start strobe; also aborts a frame in progress
//   bit_valid   bit_in is valid this cycle
//   bit_in      serial bit
//   busy        high while in DATA or PARITY
//   done        one-cycle pulse when a frame completes
//   data_out    last completed data word (held until next done)
//   parity_err  error flag of last completed frame (held until next done)
//   err_count   errored-frame count, saturating at ERR_CNT_MAX
// -----------------------------------------------------------------------------
module serial_parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    // Counter is wide enough to hold DATA_BITS, so it never wraps in a frame.
    localparam int               CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    state_t                 state_reg;
    logic                   acc_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic [DATA_BITS-1:0]   data_out_reg;
    logic                   parity_err_reg;
    logic [ERR_CNT_W-1:0]   err_count_reg;

    logic [DATA_BITS-1:0]   sr_q;
    logic                   sr_shift;
    logic                   frame_err_next;

    // start always wins: it both clears the register and suppresses the
    // shift of any bit presented in the same cycle.
    assign sr_shift       = (state_reg == ST_DATA) && bit_valid && !start;
    assign frame_err_next = (acc_reg ^ bit_in) != ODD_PARITY;

    serial_shift_reg #(
        .DATA_BITS (DATA_BITS)
    ) u_shift_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start),
        .shift_en (sr_shift),
        .bit_in   (bit_in),
        .data_q   (sr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            acc_reg        <= 1'b0;
            cnt_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            data_out_reg   <= '0;
            parity_err_reg <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                // New frame or abort of the current one; no done for an abort.
                state_reg <= ST_DATA;
                acc_reg   <= 1'b0;
                cnt_reg   <= '0;
                busy_reg  <= 1'b1;
            end else begin
                case (state_reg)
                    ST_DATA: begin
                        if (bit_valid) begin
                            acc_reg <= acc_reg ^ bit_in;
                            cnt_reg <= cnt_reg + CNT_W'(1);
                            if (cnt_reg == LAST_IDX) begin
                                state_reg <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_valid) begin
                            data_out_reg   <= sr_q;
                            parity_err_reg <= frame_err_next;
                            done_reg       <= 1'b1;
                            busy_reg       <= 1'b0;
                            state_reg      <= ST_IDLE;
                            if (frame_err_next && (err_count_reg != ERR_CNT_MAX)) begin
                                err_count_reg <= err_count_reg + ERR_CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        // IDLE (and the unused encoding): bits are ignored.
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign data_out   = data_out_reg;
    assign parity_err = parity_err_reg;
    assign err_count  = err_count_reg;

endmodule

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_checker
// Drives the same serial stream into an even-parity and an odd-parity checker
// and compares both against a frame-level reference model (parity computed
// from the popcount of the word and the parity bit).
// -----------------------------------------------------------------------------
module tb_serial_parity_checker;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          bit_valid;
    logic          bit_in;

    logic          busy_e, done_e, parity_err_e;
    logic [DB-1:0] data_out_e;
    logic [7:0]    err_count_e;
    logic          busy_o, done_o, parity_err_o;
    logic [DB-1:0] data_out_o;
    logic [7:0]    err_count_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt_e   = 0;
    int done_cnt_o   = 0;

    // Reference model state
    int exp_done    = 0;
    int exp_cnt_e   = 0;
    int exp_cnt_o   = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(
        .DATA_BITS  (DB),
        .ODD_PARITY (1'b0)
    ) dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .busy       (busy_e),
        .done       (done_e),
        .data_out   (data_out_e),
        .parity_err (parity_err_e),
        .err_count  (err_count_e)
    );

    serial_parity_checker #(
        .DATA_BITS  (DB),
        .ODD_PARITY (1'b1)
    ) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .busy       (busy_o),
        .done       (done_o),
        .data_out   (data_out_o),
        .parity_err (parity_err_o),
        .err_count  (err_count_o)
    );

    // Count done pulses away from the active edge; a stuck done over-counts.
    always @(negedge clk) begin
        if (done_e) done_cnt_e++;
        if (done_o) done_cnt_o++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full frame. Start cycle always carries bit_valid=1 with a random bit,
    // which the design must ignore. Returns in the DONE cycle so a following
    // call issues its start back-to-back.
    task automatic run_frame(input logic [7:0] word, input logic par,
                             input int gap_at, input int gap_len, input string name);
        int cycles;
        int waited;
        int ones;
        logic err_e, err_o;
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'($urandom_range(0, 1));
        tick();
        cycles = 1;
        start  = 1'b0;
        check({name, "/busy_on"}, 32'(busy_e), 32'd1);
        for (int i = 0; i < DB; i++) begin
            bit_valid = 1'b1;
            bit_in    = word[i];
            tick();
            cycles++;
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom_range(0, 1));
                    tick();
                    cycles++;
                end
            end
        end
        bit_valid = 1'b1;
        bit_in    = par;
        tick();
        cycles++;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        waited = 0;
        while (!done_e && waited < 16) begin
            tick();
            cycles++;
            waited++;
        end
        // Reference: total ones over data+parity decides the outcome.
        ones  = $countones(word) + int'(par);
        err_e = (ones % 2) != 0;
        err_o = (ones % 2) != 1;
        exp_done++;
        if (err_e && exp_cnt_e < 255) exp_cnt_e++;
        if (err_o && exp_cnt_o < 255) exp_cnt_o++;
        check({name, "/done_e"},    32'(done_e), 32'd1);
        check({name, "/done_o"},    32'(done_o), 32'd1);
        check({name, "/latency"},   32'(cycles), 32'(DB + 2 + ((gap_at >= 0) ? gap_len : 0)));
        check({name, "/busy_off"},  32'(busy_e), 32'd0);
        check({name, "/data_e"},    32'(data_out_e), 32'(word));
        check({name, "/data_o"},    32'(data_out_o), 32'(word));
        check({name, "/perr_e"},    32'(parity_err_e), 32'(err_e));
        check({name, "/perr_o"},    32'(parity_err_o), 32'(err_o));
        check({name, "/errcnt_e"},  32'(err_count_e), 32'(exp_cnt_e));
        check({name, "/errcnt_o"},  32'(err_count_o), 32'(exp_cnt_o));
        $display("[TB] frame %s word=0x%02h par=%0d lat=%0d data=0x%02h perr_e=%0d perr_o=%0d cnt_e=%0d cnt_o=%0d",
                 name, word, par, cycles, data_out_e, parity_err_e, parity_err_o, err_count_e, err_count_o);
    endtask

    // Start a frame and send only nbits data bits, leaving it unfinished.
    task automatic start_partial(input int nbits);
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(0, 1));
            tick();
        end
        bit_valid = 1'b0;
        $display("[TB] partial frame, %0d bits sent", nbits);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "/busy_e"},   32'(busy_e), 32'd0);
        check({name, "/done_e"},   32'(done_e), 32'd0);
        check({name, "/data_e"},   32'(data_out_e), 32'd0);
        check({name, "/perr_e"},   32'(parity_err_e), 32'd0);
        check({name, "/cnt_e"},    32'(err_count_e), 32'd0);
        check({name, "/busy_o"},   32'(busy_o), 32'd0);
        check({name, "/data_o"},   32'(data_out_o), 32'd0);
        check({name, "/cnt_o"},    32'(err_count_o), 32'd0);
        $display("[TB] reset values checked (%s)", name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic       p;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (3) tick();
        check_reset_values("por");
        rst_n = 1'b1;
        tick();

        // Clean even frame, then parity error with a 3-cycle gap after bit 3.
        run_frame(8'hA5, 1'b0, -1, 0, "clean_even");
        run_frame(8'hA5, 1'b1, 3, 3, "gap_err");
        // Odd-parity cases (both instances see both).
        run_frame(8'h00, 1'b1, -1, 0, "zero_p1");
        run_frame(8'h00, 1'b0, -1, 0, "zero_p0");
        tick();
        check("done_total_1", 32'(done_cnt_e), 32'(exp_done));

        // Abort after 5 bits, then a full 0x3C frame: exactly one done.
        start_partial(5);
        run_frame(8'h3C, 1'b0, -1, 0, "after_abort");
        tick();
        check("done_total_abort_e", 32'(done_cnt_e), 32'(exp_done));
        check("done_total_abort_o", 32'(done_cnt_o), 32'(exp_done));

        // Asynchronous reset mid-frame.
        start_partial(4);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        #3 rst_n = 1'b1;
        exp_cnt_e = 0;
        exp_cnt_o = 0;
        for (int i = 0; i < 12; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(0, 1));
            tick();
        end
        bit_valid = 1'b0;
        tick();
        check("no_done_after_rst", 32'(done_cnt_e), 32'(exp_done));
        check("idle_after_rst",    32'(busy_e), 32'd0);

        // Bits in IDLE without start are ignored.
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(0, 1));
            tick();
            check("idle_ignore_busy", 32'(busy_e), 32'd0);
        end
        bit_valid = 1'b0;
        tick();
        check("idle_ignore_done", 32'(done_cnt_e), 32'(exp_done));

        // Randomized frames with random gaps.
        for (int n = 0; n < 20; n++) begin
            w = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                run_frame(w, p, int'($urandom_range(0, DB - 1)), int'($urandom_range(1, 4)), "random");
            else
                run_frame(w, p, -1, 0, "random");
        end

        // 260 back-to-back frames, all errored for the even checker.
        for (int n = 0; n < 260; n++) begin
            w = 8'($urandom);
            p = ~(^w);
            run_frame(w, p, -1, 0, "sat");
        end
        check("sat_hold_e", 32'(err_count_e), 32'd255);
        tick();
        check("done_total_end_e", 32'(done_cnt_e), 32'(exp_done));
        check("done_total_end_o", 32'(done_cnt_o), 32'(exp_done));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

- Receives a framed serial bit stream, one qualified bit per clock.
- Accumulates the running XOR parity of each frame and captures the data word.
- At frame end, reports the word and a parity-error flag, and keeps a saturating error count.
- Sits downstream of the XOR parity stage: it consumes serialized data and parity bits and checks them.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 1..32.
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  frame-start strobe; one-cycle pulse.
- BIT_VALID  input  1  BIT_IN is valid this cycle.
- BIT_IN  input  1  serial bit; data bits are sent LSB first, then one parity bit.
- BUSY  output  1  high while in DATA or PARITY state.
- DONE  output  1  one-cycle pulse when a frame completes.
- DATA_OUT  output  DATA_BITS  last completed data word; held until the next DONE.
- PARITY_ERR  output  1  error flag of the last completed frame; held until the next DONE.
- ERR_COUNT  output  8  count of errored frames; saturates at 255.

## Operation
- States: IDLE, DATA, PARITY. Encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2.
- **IDLE**
  - START=1: clear the accumulator, bit counter and shift register; go to DATA.
  - BIT_VALID is ignored in IDLE, including a BIT_VALID in the same cycle as START.
- **DATA**, on each BIT_VALID=1:
  - shift register: sr <= {BIT_IN, sr[DATA_BITS-1:1]}, so bit 0 lands in DATA_OUT[0];
  - acc <= acc ^ BIT_IN;
  - cnt <= cnt + 1.
  - Exit: when the accepted bit is bit DATA_BITS-1, go to PARITY.
  - BIT_VALID=0 cycles are gaps; state is held.
- **PARITY**, on BIT_VALID=1:
  - err = (acc ^ BIT_IN) != ODD_PARITY;
  - register DATA_OUT <= sr, PARITY_ERR <= err, DONE <= 1;
  - ERR_COUNT increments if err and below 255;
  - go to IDLE.
- START in DATA or PARITY aborts the frame:
  - no DONE;
  - accumulator, counter and shift register are cleared;
  - state goes to DATA. Any bit in the same cycle is ignored.
- The counter width is $clog2(DATA_BITS+1); it never wraps inside a frame.
- Exactly one unregistered mismatch is impossible: all outputs are registered.

## Timing
- Reset values: BUSY=0, DONE=0, DATA_OUT=0, PARITY_ERR=0, ERR_COUNT=0, state IDLE.
- RST_N low mid-frame: the frame is lost immediately and asynchronously; no DONE afterwards.
- BUSY goes high the cycle after START is sampled. It goes low in the same cycle DONE goes high.
- DONE is high exactly one cycle, the cycle after the parity bit is sampled.
- Minimum frame latency is START at cycle 0 to DONE at cycle DATA_BITS+2. This applies with BIT_VALID held high from cycle 1.
- START may be asserted in the DONE cycle. The next frame's first bit may then be sampled the following cycle, giving back-to-back frames with no idle gap.
- ERR_COUNT updates in the DONE cycle. At 255 it stays 255; there is no wrap.

## Structure
- Package parity_pkg holds:
  - the state encoding constants (ST_IDLE, ST_DATA, ST_PARITY);
  - the ERR_COUNT width (8) and its saturation value (255).
- Sub-module serial_shift_reg, parameterised by DATA_BITS: shift-enable, synchronous clear, parallel output.
- The FSM, parity accumulator and error counter stay in the top module.

## Test plan
- **Clean even frame.** DATA_BITS=8, ODD_PARITY=0, START, then 0xA5 LSB first, then parity 0, with BIT_VALID continuous.
  - DONE at cycle 10, DATA_OUT=0xA5, PARITY_ERR=0, ERR_COUNT=0.
- **Parity error with gaps.** Same frame with parity 1, and BIT_VALID low for 3 cycles after bit 3.
  - DONE at cycle 13, PARITY_ERR=1, ERR_COUNT=1.
- **Odd parity.** ODD_PARITY=1, data 0x00, parity 1.
  - PARITY_ERR=0; with parity 0 instead, PARITY_ERR=1.
- **Abort and reset mid-frame.** START re-pulsed after 5 bits, then a full 0x3C frame with parity 0.
  - Exactly one DONE, DATA_OUT=0x3C, PARITY_ERR=0.
  - RST_N pulsed low mid-frame: all outputs return to reset values and no DONE follows.
- **Saturation and back-to-back.** 260 consecutive errored frames, each START issued in the previous DONE cycle.
  - 260 DONE pulses, ERR_COUNT reaches 255 and holds.
- **Ignored inputs.** BIT_VALID=1 in IDLE without START: no state change, BUSY=0. START and BIT_VALID together: the bit is not counted.
